// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, the NOP encoding, the fetch FSM state type
// and the default instruction ROM image.
package cpu_pkg;

  localparam int unsigned PC_W_DEF     = 5;
  localparam int unsigned INSTR_W_DEF  = 32;
  localparam int unsigned ROM_BITS_DEF = (1 << PC_W_DEF) * INSTR_W_DEF;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StHold,
    StBubble
  } fetch_state_e;

  // Default hex image: word i holds the value i, so a fetched word names its own address.
  function automatic logic [ROM_BITS_DEF-1:0] ramp_image();
    logic [ROM_BITS_DEF-1:0] img;
    img = '0;
    for (int i = 0; i < (1 << PC_W_DEF); i++) begin
      img[i*INSTR_W_DEF +: INSTR_W_DEF] = INSTR_W_DEF'(i);
    end
    return img;
  endfunction

endpackage

// File: rtl/fetch_unit_instr_rom.sv
// Synchronous-read instruction ROM with a registered data output; contents come from a flat
// hex image parameter, word 0 in the least-significant bits.
module instr_rom #(
  parameter int unsigned PC_W    = cpu_pkg::PC_W_DEF,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W_DEF,
  parameter logic [(1 << PC_W)*INSTR_W-1:0] IMAGE = '0
) (
  input  logic               clk,
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [1 << PC_W];

  for (genvar i = 0; i < (1 << PC_W); i++) begin : g_unpack
    assign mem[i] = IMAGE[i*INSTR_W +: INSTR_W];
  end

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the instruction ROM and hands one instruction
// per cycle to decode, honouring stalls and branch redirects from memory/writeback.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W             = PC_W_DEF,
  parameter int unsigned INSTR_W          = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP       = NOP_INSTR,
  parameter int unsigned REDIRECT_BUBBLES = 0,
  parameter logic [(1 << PC_W)*INSTR_W-1:0] ROM_IMAGE = ramp_image()
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               should_jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic [15:0]        redirect_count
);

  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic            valid_q, valid_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [15:0]     rcnt_q, rcnt_d;

  logic            redirect;
  logic            hold;
  logic            advance;
  logic [PC_W-1:0] rom_addr;
  logic [INSTR_W-1:0] rom_rdata;

  assign redirect = should_jump && (state_q != StFill);
  // A stalled edge re-reads if_pc so the registered ROM output is unchanged across the stall,
  // including the first stalled edge taken from RUN.
  assign hold     = !redirect && stall && ((state_q == StRun) || (state_q == StHold));
  assign rom_addr = hold ? if_pc_q : fetch_pc_q;

  instr_rom #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .IMAGE   (ROM_IMAGE)
  ) u_rom (
    .clk   (clk),
    .addr  (rom_addr),
    .rdata (rom_rdata)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if_pc_d    = if_pc_q;
    valid_d    = valid_q;
    bcnt_d     = bcnt_q;
    rcnt_d     = rcnt_q;
    advance    = 1'b0;

    if (redirect) begin
      valid_d    = 1'b0;
      fetch_pc_d = jump_target;
      bcnt_d     = 3'(REDIRECT_BUBBLES);
      state_d    = StBubble;
      if (rcnt_q != 16'hFFFF) begin
        rcnt_d = rcnt_q + 16'd1;
      end
    end else begin
      unique case (state_q)
        StFill: begin
          advance = 1'b1;
          state_d = StRun;
        end
        StRun, StHold: begin
          if (stall) begin
            state_d = StHold;
          end else begin
            advance = 1'b1;
            state_d = StRun;
          end
        end
        StBubble: begin
          if (bcnt_q != 3'd0) begin
            bcnt_d = bcnt_q - 3'd1;
          end else begin
            advance = 1'b1;
            state_d = StRun;
          end
        end
      endcase
    end

    if (advance) begin
      if_pc_d    = fetch_pc_q;
      valid_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFill;
      fetch_pc_q <= '0;
      if_pc_q    <= '0;
      valid_q    <= 1'b0;
      bcnt_q     <= 3'd0;
      rcnt_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_pc_q    <= if_pc_d;
      valid_q    <= valid_d;
      bcnt_q     <= bcnt_d;
      rcnt_q     <= rcnt_d;
    end
  end

  // ROM data is never reset; the valid flag masks it so reset shows NOP at once.
  assign if_pc          = if_pc_q;
  assign if_valid       = valid_q;
  assign if_instr       = valid_q ? rom_rdata : NOP;
  assign redirect_count = rcnt_q;

endmodule
